// File: rtl/l2_request_arbiter.sv
// N-way L2 request arbiter: round-robin or fixed priority with grant locking.
// One cycle from acceptance to out_valid; req_ready drops while the output register is held.
module l2_request_arbiter #(
  parameter int NUM_CORES      = 4,
  parameter int PACKET_WIDTH   = 128,
  parameter int CORE_ID_WIDTH  = 4,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CORES-1:0]              req_valid,
  input  logic [NUM_CORES-1:0]              req_lock,
  input  logic [NUM_CORES*PACKET_WIDTH-1:0] req_packet,
  output logic [NUM_CORES-1:0]              req_ready,
  output logic                              out_valid,
  output logic [PACKET_WIDTH-1:0]           out_packet,
  output logic [CORE_ID_WIDTH-1:0]          out_core,
  input  logic                              out_ready,
  output logic                              pc_event_arb_conflict
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  logic                     out_valid_q, out_valid_d;
  logic [PACKET_WIDTH-1:0]  out_packet_q, out_packet_d;
  logic [CORE_ID_WIDTH-1:0] out_core_q, out_core_d;
  logic                     conflict_q, conflict_d;
  idx_t                     ptr_q, ptr_d;
  logic                     lock_vld_q, lock_vld_d;
  idx_t                     lock_owner_q, lock_owner_d;

  logic slot_open;
  logic win_vld;
  idx_t win_idx;
  logic accept;
  int   cand;

  assign slot_open = !out_valid_q || out_ready;

  // Scan from the highest offset down so the lowest offset (closest to pointer) wins last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    if (lock_vld_q) begin
      win_idx = lock_owner_q;
      win_vld = req_valid[lock_owner_q];
    end else if (FIXED_PRIORITY != 0) begin
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        if (req_valid[idx_t'(i)]) begin
          win_vld = 1'b1;
          win_idx = idx_t'(i);
        end
      end
    end else begin
      for (int off = NUM_CORES - 1; off >= 0; off--) begin
        cand = int'(ptr_q) + off;
        if (cand >= NUM_CORES) cand = cand - NUM_CORES;
        if (req_valid[idx_t'(cand)]) begin
          win_vld = 1'b1;
          win_idx = idx_t'(cand);
        end
      end
    end
  end

  assign accept = slot_open && win_vld;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      req_ready[i] = accept && (win_idx == idx_t'(i));
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_packet_d = out_packet_q;
    out_core_d   = out_core_q;
    conflict_d   = 1'b0;
    ptr_d        = ptr_q;
    lock_vld_d   = lock_vld_q;
    lock_owner_d = lock_owner_q;
    if (accept) begin
      out_valid_d  = 1'b1;
      out_packet_d = req_packet[int'(win_idx)*PACKET_WIDTH +: PACKET_WIDTH];
      out_core_d   = CORE_ID_WIDTH'(win_idx);
      conflict_d   = ($countones(req_valid) >= 2);
      lock_vld_d   = req_lock[win_idx];
      lock_owner_d = win_idx;
      if (FIXED_PRIORITY == 0) begin
        ptr_d = (win_idx == idx_t'(NUM_CORES - 1)) ? idx_t'(0) : idx_t'(win_idx + 1'b1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_packet_q <= '0;
      out_core_q   <= '0;
      conflict_q   <= 1'b0;
      ptr_q        <= '0;
      lock_vld_q   <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_packet_q <= out_packet_d;
      out_core_q   <= out_core_d;
      conflict_q   <= conflict_d;
      ptr_q        <= ptr_d;
      lock_vld_q   <= lock_vld_d;
      lock_owner_q <= lock_owner_d;
    end
  end

  assign out_valid             = out_valid_q;
  assign out_packet            = out_packet_q;
  assign out_core              = out_core_q;
  assign pc_event_arb_conflict = conflict_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Bench for l2_request_arbiter: round-robin instance checked through a core-id scoreboard,
// fixed-priority instance checked directly.
module tb_l2_request_arbiter;
  localparam int N  = 4;
  localparam int PW = 128;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    a_valid, a_lock, a_ready;
  logic [N*PW-1:0] a_pkt;
  logic            a_out_valid, a_out_ready, a_conf;
  logic [PW-1:0]   a_out_pkt;
  logic [CW-1:0]   a_out_core;

  logic [N-1:0]    b_valid, b_lock, b_ready;
  logic [N*PW-1:0] b_pkt;
  logic            b_out_valid, b_out_ready, b_conf;
  logic [PW-1:0]   b_out_pkt;
  logic [CW-1:0]   b_out_core;

  l2_request_arbiter #(.NUM_CORES(N), .PACKET_WIDTH(PW), .CORE_ID_WIDTH(CW), .FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .reset(reset), .req_valid(a_valid), .req_lock(a_lock), .req_packet(a_pkt),
    .req_ready(a_ready), .out_valid(a_out_valid), .out_packet(a_out_pkt), .out_core(a_out_core),
    .out_ready(a_out_ready), .pc_event_arb_conflict(a_conf));

  l2_request_arbiter #(.NUM_CORES(N), .PACKET_WIDTH(PW), .CORE_ID_WIDTH(CW), .FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .reset(reset), .req_valid(b_valid), .req_lock(b_lock), .req_packet(b_pkt),
    .req_ready(b_ready), .out_valid(b_out_valid), .out_packet(b_out_pkt), .out_core(b_out_core),
    .out_ready(b_out_ready), .pc_event_arb_conflict(b_conf));

  int total = 0;
  int bad   = 0;
  int q[$];
  int seq[N];
  int exp_cnt[N];

  task automatic chk(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input int c, input int s);
    return {8'(c), 24'hC0FFEE, 32'(s) * 32'h9E3779B9, 32'h5A5A0000 ^ 32'(c << 8), 32'(s)};
  endfunction

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      a_pkt[i*PW +: PW] = mk_pkt(i, seq[i]);
      b_pkt[i*PW +: PW] = mk_pkt(i, 0);
    end
  endtask

  // One clock on the round-robin instance: consume output, advance accepted cores.
  task automatic tick();
    logic [N-1:0] acc;
    int nreq;
    int c;
    #1;
    acc  = a_ready & a_valid;
    nreq = $countones(a_valid);
    if (a_out_valid && a_out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", a_out_valid, 1'b0);
      end else begin
        c = q.pop_front();
        chk("sb_core", a_out_core, c);
        chk("sb_pkt", a_out_pkt, mk_pkt(c, exp_cnt[c]));
        exp_cnt[c]++;
      end
    end
    @(posedge clk);
    #1;
    chk("conflict", a_conf, (acc != 0) && (nreq >= 2));
    for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
    refresh();
  endtask

  task automatic sb_sync();
    q.delete();
    for (int i = 0; i < N; i++) exp_cnt[i] = seq[i];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    sb_sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    a_valid = '0; a_lock = '0; a_out_ready = 1'b1;
    b_valid = '0; b_lock = '0; b_out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin seq[i] = 0; exp_cnt[i] = 0; end
    refresh();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_valid", a_out_valid, 1'b0);
    chk("rst_core", a_out_core, 0);
    chk("rst_pkt", a_out_pkt, '0);
    chk("rst_conf", a_conf, 1'b0);
    chk("rst_ready", a_ready, 4'b0000);
    chk("rst_fp_valid", b_out_valid, 1'b0);

    // All four cores streaming: 0,1,2,3,0,1 with wrap.
    foreach (q[i]) ;
    q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(3); q.push_back(0); q.push_back(1);
    a_valid = 4'b1111;
    #1 chk("t1_first_ready", a_ready, 4'b0001);
    repeat (6) tick();
    a_valid = '0;
    tick();
    chk("t1_drained", a_out_valid, 1'b0);

    // Only cores 1 and 3: idle cores skipped, no bubbles.
    do_reset();
    q.push_back(1); q.push_back(3); q.push_back(1); q.push_back(3);
    a_valid = 4'b1010;
    repeat (4) begin
      tick();
      chk("t2_nobubble", a_out_valid, 1'b1);
    end
    a_valid = '0;
    tick();
    tick();

    // Core 2 locks for two packets; core 0 waits even while core 2 is idle.
    do_reset();
    q.push_back(1); q.push_back(2); q.push_back(2); q.push_back(2); q.push_back(0);
    a_valid = 4'b0010;
    tick();
    a_valid = 4'b0101; a_lock = 4'b0100;
    tick();
    tick();
    a_valid = 4'b0001;
    repeat (2) begin
      #1 chk("t3_locked_ready", a_ready, 4'b0000);
      tick();
    end
    a_valid = 4'b0101; a_lock = 4'b0000;
    #1 chk("t3_owner_ready", a_ready, 4'b0100);
    tick();
    a_valid = 4'b0001;
    tick();
    a_valid = '0;
    tick();
    tick();

    // Output stalled for five cycles holding core 1's packet.
    do_reset();
    q.push_back(1); q.push_back(2); q.push_back(0);
    a_valid = 4'b0010;
    tick();
    a_out_ready = 1'b0;
    a_valid = 4'b0101;
    repeat (5) begin
      #1;
      chk("t4_ready_stall", a_ready, 4'b0000);
      chk("t4_valid_hold", a_out_valid, 1'b1);
      chk("t4_core_hold", a_out_core, 1);
      chk("t4_pkt_hold", a_out_pkt, mk_pkt(1, exp_cnt[1]));
      tick();
    end
    a_out_ready = 1'b1;
    #1 chk("t4_ready_release", a_ready, 4'b0100);
    tick();
    chk("t4_nobubble", a_out_valid, 1'b1);
    a_valid = 4'b0001;
    tick();
    a_valid = '0;
    tick();

    // Async reset while a locked packet from core 1 is held.
    do_reset();
    a_valid = 4'b0010; a_lock = 4'b0010; a_out_ready = 1'b0;
    tick();
    a_valid = '0; a_lock = '0;
    #1 chk("t6_held", a_out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", a_out_valid, 1'b0);
    chk("t6_async_core", a_out_core, 0);
    chk("t6_async_pkt", a_out_pkt, '0);
    reset = 1'b0;
    sb_sync();
    a_out_ready = 1'b1;
    a_valid = 4'b0011;
    q.push_back(0); q.push_back(1);
    #1 chk("t6_core0_first", a_ready, 4'b0001);
    tick();
    a_valid = 4'b0010;
    tick();
    a_valid = '0;
    tick();

    // Fixed priority: core 0 starves core 3 until it drops.
    b_valid = 4'b1001;
    repeat (4) begin
      #1 chk("t5_ready", b_ready, 4'b0001);
      @(posedge clk);
      #1 chk("t5_core", b_out_core, 0);
      chk("t5_conf", b_conf, 1'b1);
    end
    b_valid = 4'b1000;
    #1 chk("t5_ready3", b_ready, 4'b1000);
    @(posedge clk);
    #1;
    chk("t5_core3", b_out_core, 3);
    chk("t5_pkt3", b_out_pkt, mk_pkt(3, 0));
    chk("t5_conf3", b_conf, 1'b0);
    b_valid = '0;
    @(posedge clk);
    #1 chk("t5_drained", b_out_valid, 1'b0);

    chk("sb_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
